// File: rtl/apb_global_pkg.sv
// Shared APB types and default bus widths used by the completer and its memory.
package apb_global_pkg;

    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam int unsigned DATA_WIDTH    = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tx_type_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } slave_error_e;

    // pprot[0]=privileged, pprot[1]=non-secure, pprot[2]=instruction
    typedef enum logic [2:0] {
        DATA_SECURE_NPRIV   = 3'b000,
        DATA_SECURE_PRIV    = 3'b001,
        DATA_NSECURE_NPRIV  = 3'b010,
        DATA_NSECURE_PRIV   = 3'b011,
        INSTR_SECURE_NPRIV  = 3'b100,
        INSTR_SECURE_PRIV   = 3'b101,
        INSTR_NSECURE_NPRIV = 3'b110,
        INSTR_NSECURE_PRIV  = 3'b111
    } protection_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_byte_mem.sv
// Word-addressed storage with byte-lane write strobes; contents are not reset.
module apb_slave_byte_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 16,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [STRB_W-1:0]     i_wstrb,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Synchronous write, only the strobed byte lanes change
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer backed by a small byte-strobed memory, with programmable
// wait states, access checking and a saturating error counter.
module apb_slave_mem_responder #(
    parameter int unsigned ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
    parameter int unsigned MEM_WORDS     = 16,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                cfg_wait_states,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic [7:0]                err_count
);

    import apb_global_pkg::*;

    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned BYTE_OFF_W = $clog2(STRB_W);
    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned MEM_BYTES  = MEM_WORDS * STRB_W;
    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);

    apb_slave_state_e            r_state;
    logic [ADDRESS_WIDTH-1:0]    r_addr;
    tx_type_e                    r_write;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic [STRB_W-1:0]           r_strb;
    logic                        r_priv;
    logic [3:0]                  r_wait_cnt;
    logic                        r_pready;
    logic [DATA_WIDTH-1:0]       r_prdata;
    slave_error_e                r_pslverr;
    logic [7:0]                  r_err_count;

    logic                        w_setup;
    logic                        w_access_ok;
    logic                        w_live;
    logic [ADDRESS_WIDTH-1:0]    w_addr;
    tx_type_e                    w_write;
    logic [STRB_W-1:0]           w_strb;
    logic                        w_priv;
    logic [ADDRESS_WIDTH-1:0]    w_offset;
    logic [IDX_W-1:0]            w_word_idx;
    logic                        w_in_range;
    logic                        w_misaligned;
    logic                        w_null_wr;
    logic                        w_priv_viol;
    logic                        w_err;
    logic                        w_load_cmpl;
    logic                        w_complete;
    logic                        w_mem_we;
    logic [DATA_WIDTH-1:0]       w_mem_rdata;
    logic                        w_unused_prot;

    assign w_setup     = psel && !penable;
    assign w_access_ok = psel && penable;

    // A zero-wait transfer must have its response ready at the setup edge, so
    // the checks look at the live bus in IDLE and at the latched fields after.
    assign w_live  = (r_state == IDLE);
    assign w_addr  = w_live ? paddr              : r_addr;
    assign w_write = w_live ? tx_type_e'(pwrite) : r_write;
    assign w_strb  = w_live ? pstrb              : r_strb;
    assign w_priv  = w_live ? pprot[0]           : r_priv;

    // Only the privilege bit matters to this completer
    assign w_unused_prot = ^pprot[2:1];

    assign w_offset     = w_addr - BASE;
    assign w_word_idx   = IDX_W'(w_offset >> BYTE_OFF_W);
    assign w_in_range   = (w_addr >= BASE) && (w_offset < ADDRESS_WIDTH'(MEM_BYTES));
    assign w_misaligned = (w_addr & ADDRESS_WIDTH'(STRB_W - 1)) != '0;
    assign w_null_wr    = (w_write == WRITE) && (w_strb == '0);
    assign w_priv_viol  = !w_priv && w_word_idx[IDX_W-1];
    assign w_err        = !w_in_range || w_misaligned || w_null_wr || w_priv_viol;

    // Response is registered one edge ahead of the cycle in which pready shows
    assign w_load_cmpl = (w_live && w_setup && (cfg_wait_states == 4'd0)) ||
                         ((r_state == ACCESS) && w_access_ok && !r_pready &&
                          (r_wait_cnt == 4'd1));
    assign w_complete  = (r_state == ACCESS) && w_access_ok && r_pready;
    assign w_mem_we    = w_complete && (r_write == WRITE) && (r_pslverr == OKAY);

    apb_slave_byte_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_mem (
        .i_clk   (pclk),
        .i_we    (w_mem_we),
        .i_waddr (w_word_idx),
        .i_wstrb (r_strb),
        .i_wdata (r_wdata),
        .i_raddr (w_word_idx),
        .o_rdata (w_mem_rdata)
    );

    // Transfer FSM: latch the request at setup, count waits, drop on abort
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_write    <= READ;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_priv     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_state    <= ACCESS;
                        r_addr     <= paddr;
                        r_write    <= tx_type_e'(pwrite);
                        r_wdata    <= pwdata;
                        r_strb     <= pstrb;
                        r_priv     <= pprot[0];
                        r_wait_cnt <= cfg_wait_states;
                    end
                end
                ACCESS: begin
                    if (!w_access_ok || r_pready) begin
                        r_state <= IDLE;
                    end else if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Response registers and error counter; pready/pslverr are single-cycle
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_pready    <= 1'b0;
            r_prdata    <= '0;
            r_pslverr   <= OKAY;
            r_err_count <= '0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= OKAY;
            if (w_load_cmpl) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err ? ERROR : OKAY;
                if (w_write == READ) begin
                    r_prdata <= w_err ? '0 : w_mem_rdata;
                end
            end
            if (w_complete && (r_pslverr == ERROR) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign pready    = r_pready;
    assign prdata    = r_prdata;
    assign pslverr   = (r_pslverr == ERROR);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Bench for apb_slave_mem_responder: directed vector table, hand-written
// abort/reset sequences and a randomized run against a behavioural model.
module tb_apb_slave_mem_responder;

    localparam logic [31:0] TB_BASE = 32'h0000_1000;

    logic        pclk;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  cfg_wait_states;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [7:0]  err_count;

    apb_slave_mem_responder #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_WORDS     (16),
        .BASE_ADDR     (TB_BASE)
    ) dut (
        .pclk            (pclk),
        .preset_n        (preset_n),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .pprot           (pprot),
        .cfg_wait_states (cfg_wait_states),
        .pready          (pready),
        .prdata          (prdata),
        .pslverr         (pslverr),
        .err_count       (err_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [20];
    logic [31:0] m_mem [16];
    logic [31:0] m_last_rd;
    logic [7:0]  m_err_cnt;
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Access rules: inside the 64-byte window, word aligned, no empty write,
    // upper 32 bytes need the privileged pprot bit.
    function automatic bit model_err(input bit wr, input logic [31:0] addr,
                                     input logic [3:0] strb, input logic [2:0] prot);
        logic [31:0] off;
        bit          outside;
        off     = addr - TB_BASE;
        outside = (addr < TB_BASE) || (off >= 32'd64);
        return outside || (addr[1:0] != 2'b00) || (wr && strb == 4'h0) ||
               (!outside && !prot[0] && off >= 32'd32);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // One full APB transfer; bus fields are scrambled during ACCESS.
    task automatic run_xfer(input string tag, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, input int waits,
                            input bit exp_err, input logic [31:0] exp_rd);
        int          k;
        bit          seen;
        bit          quiet;
        logic [31:0] got_rd;
        logic        got_err;
        @(negedge pclk);
        check($sformatf("%s err_count", tag), 32'(err_count), 32'(m_err_cnt));
        psel            = 1'b1;
        penable         = 1'b0;
        pwrite          = wr;
        paddr           = addr;
        pwdata          = wdata;
        pstrb           = strb;
        pprot           = prot;
        cfg_wait_states = 4'(waits);
        k       = 0;
        seen    = 1'b0;
        quiet   = 1'b1;
        got_rd  = '0;
        got_err = 1'b0;
        while (!seen && k < 40) begin
            @(negedge pclk);
            k++;
            if (pready) begin
                seen    = 1'b1;
                got_rd  = prdata;
                got_err = pslverr;
            end else if (pslverr) begin
                quiet = 1'b0;
            end
            penable         = 1'b1;
            paddr           = $urandom;
            pwdata          = $urandom;
            cfg_wait_states = 4'($urandom);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no pready within %0d cycles", tag, k);
            psel    = 1'b0;
            penable = 1'b0;
        end else begin
            check($sformatf("%s latency", tag), 32'(k), 32'(waits + 1));
            check($sformatf("%s pslverr", tag), 32'(got_err), 32'(exp_err));
            check($sformatf("%s pslverr_quiet", tag), 32'(quiet), 32'd1);
            if (wr) begin
                check($sformatf("%s prdata_hold", tag), got_rd, m_last_rd);
            end else begin
                check($sformatf("%s prdata", tag), got_rd, exp_rd);
                m_last_rd = exp_rd;
            end
            if (exp_err && m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          wr;
        bit          e;
        bit          seen;
        int          sel;
        int          waits;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [3:0]  idx;
        logic [31:0] exp;

        n_vec     = 0;
        n_err     = 0;
        m_last_rd = '0;
        m_err_cnt = '0;
        preset_n  = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        pstrb     = '0;
        pprot     = '0;
        cfg_wait_states = '0;

        tbl[0]  = '{1, TB_BASE + 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, 0,  0, 32'h0};
        tbl[1]  = '{0, TB_BASE + 32'h04, 32'h0,        4'hF, 3'b001, 0,  0, 32'hDEADBEEF};
        tbl[2]  = '{1, TB_BASE + 32'h08, 32'hAABBCCDD, 4'hF, 3'b001, 0,  0, 32'h0};
        tbl[3]  = '{1, TB_BASE + 32'h08, 32'h11223344, 4'h5, 3'b001, 0,  0, 32'h0};
        tbl[4]  = '{0, TB_BASE + 32'h08, 32'h0,        4'h0, 3'b001, 0,  0, 32'hAA22CC44};
        tbl[5]  = '{0, TB_BASE + 32'h04, 32'h0,        4'h0, 3'b001, 3,  0, 32'hDEADBEEF};
        tbl[6]  = '{1, TB_BASE + 32'h40, 32'h12345678, 4'hF, 3'b001, 0,  1, 32'h0};
        tbl[7]  = '{1, TB_BASE + 32'h02, 32'h12345678, 4'hF, 3'b001, 1,  1, 32'h0};
        tbl[8]  = '{1, TB_BASE + 32'h04, 32'hCAFEF00D, 4'h0, 3'b001, 2,  1, 32'h0};
        tbl[9]  = '{0, TB_BASE + 32'h04, 32'h0,        4'h0, 3'b001, 0,  0, 32'hDEADBEEF};
        tbl[10] = '{1, TB_BASE + 32'h20, 32'h55667788, 4'hF, 3'b000, 0,  1, 32'h0};
        tbl[11] = '{1, TB_BASE + 32'h20, 32'h99AABBCC, 4'hF, 3'b001, 0,  0, 32'h0};
        tbl[12] = '{0, TB_BASE + 32'h20, 32'h0,        4'h0, 3'b001, 0,  0, 32'h99AABBCC};
        tbl[13] = '{0, TB_BASE + 32'h20, 32'h0,        4'h0, 3'b000, 1,  1, 32'h0};
        tbl[14] = '{1, TB_BASE + 32'h1C, 32'h0BADC0DE, 4'hF, 3'b000, 0,  0, 32'h0};
        tbl[15] = '{0, TB_BASE + 32'h1C, 32'h0,        4'h0, 3'b000, 0,  0, 32'h0BADC0DE};
        tbl[16] = '{0, TB_BASE + 32'h44, 32'h0,        4'h0, 3'b001, 1,  1, 32'h0};
        tbl[17] = '{1, TB_BASE + 32'h3C, 32'hFEDCBA98, 4'hF, 3'b001, 0,  0, 32'h0};
        tbl[18] = '{0, TB_BASE + 32'h3C, 32'h0,        4'h0, 3'b001, 15, 0, 32'hFEDCBA98};
        tbl[19] = '{0, TB_BASE - 32'h04, 32'h0,        4'h0, 3'b001, 0,  1, 32'h0};

        // Reset state
        repeat (3) @(negedge pclk);
        check("reset pready", 32'(pready), 32'd0);
        check("reset prdata", prdata, 32'd0);
        check("reset pslverr", 32'(pslverr), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        preset_n = 1'b1;
        idle(2);

        // Directed vectors
        for (int i = 0; i < 20; i++) begin
            run_xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                     tbl[i].strb, tbl[i].prot, tbl[i].waits, tbl[i].exp_err, tbl[i].exp_rd);
            idle(1);
        end

        // Abort by dropping psel during the wait states
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = TB_BASE + 32'h08;
        pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b001; cfg_wait_states = 4'd5;
        seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge pclk);
            if (pready) seen = 1'b1;
            if (k == 1) penable = 1'b1;
            if (k == 2) begin psel = 1'b0; penable = 1'b0; end
        end
        check("abort_psel no_pready", 32'(seen), 32'd0);
        run_xfer("abort_psel readback", 0, TB_BASE + 32'h08, 32'h0, 4'h0, 3'b001, 0, 0, 32'hAA22CC44);
        idle(1);

        // Abort by penable staying low in the first access cycle
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = TB_BASE + 32'h08;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001; cfg_wait_states = 4'd1;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge pclk);
            if (pready) seen = 1'b1;
            if (k == 2) psel = 1'b0;
        end
        check("abort_penable no_pready", 32'(seen), 32'd0);
        run_xfer("abort_penable readback", 0, TB_BASE + 32'h08, 32'h0, 4'h0, 3'b001, 2, 0, 32'hAA22CC44);
        idle(1);

        // Reset in the middle of a waited write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = TB_BASE + 32'h04;
        pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b001; cfg_wait_states = 4'd5;
        seen = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge pclk);
            if (pready) seen = 1'b1;
            penable = 1'b1;
        end
        preset_n = 1'b0;
        #1;
        check("midreset no_pready", 32'(seen), 32'd0);
        check("midreset pready", 32'(pready), 32'd0);
        check("midreset prdata", prdata, 32'd0);
        check("midreset pslverr", 32'(pslverr), 32'd0);
        check("midreset err_count", 32'(err_count), 32'd0);
        m_err_cnt = '0;
        m_last_rd = '0;
        @(negedge pclk);
        preset_n = 1'b1;
        psel     = 1'b0;
        penable  = 1'b0;
        run_xfer("midreset readback", 0, TB_BASE + 32'h04, 32'h0, 4'h0, 3'b001, 0, 0, 32'hDEADBEEF);

        // Fill memory so every random read has a known value
        for (int w = 0; w < 16; w++) begin
            wdata    = $urandom;
            m_mem[w] = wdata;
            run_xfer("fill", 1, TB_BASE + 32'(4 * w), wdata, 4'hF, 3'b001,
                     int'($urandom_range(0, 2)), 0, 32'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       addr = TB_BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) addr = TB_BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (sel == 8) addr = TB_BASE + 32'h40 + 32'(4 * $urandom_range(0, 31));
            else               addr = TB_BASE - 32'(4 * $urandom_range(1, 8));
            strb  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            prot  = 3'($urandom_range(0, 7));
            waits = int'($urandom_range(0, 4));
            wdata = $urandom;
            e     = model_err(wr, addr, strb, prot);
            idx   = 4'((addr - TB_BASE) >> 2);
            if (wr) begin
                run_xfer($sformatf("rnd%0d wr", i), 1, addr, wdata, strb, prot, waits, e, 32'h0);
                if (!e) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) m_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end
            end else begin
                exp = e ? 32'h0 : m_mem[idx];
                run_xfer($sformatf("rnd%0d rd", i), 0, addr, wdata, strb, prot, waits, e, exp);
            end
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        // Back-to-back errored transfers drive the counter into saturation
        for (int i = 0; i < 260; i++) begin
            run_xfer("sat", 1, TB_BASE + 32'h80, 32'h0, 4'hF, 3'b001, 0, 1, 32'h0);
        end
        idle(2);
        check("sat err_count", 32'(err_count), 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem_responder.md
Name: apb_slave_mem_responder

Overview:
Synthesizable APB4 completer (slave) that answers transfers issued by the APB master on one decoded pselx line. It holds a small word-addressed memory with per-byte write strobes and inserts a programmable number of wait states. It flags pslverr on illegal accesses. One instance sits behind each pselx bit, with index 0..NO_OF_SLAVES-1.

Parameters:
ADDRESS_WIDTH, 32, paddr width (max 32).
DATA_WIDTH, 32, pwdata/prdata width; must be 8, 16 or 32.
MEM_WORDS, 16, memory depth in DATA_WIDTH words; must be a power of 2.
BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave; aligned to MEM_WORDS*DATA_WIDTH/8.

Ports:
pclk  input  1  APB clock; all logic on rising edge.
preset_n  input  1  asynchronous active-low reset.
psel  input  1  this slave's pselx bit.
penable  input  1  access-phase indicator.
pwrite  input  1  1 = write, 0 = read (tx_type_e encoding).
paddr  input  ADDRESS_WIDTH  byte address.
pwdata  input  DATA_WIDTH  write data.
pstrb  input  DATA_WIDTH/8  write byte-lane strobes.
pprot  input  3  protection type (protection_type_e).
cfg_wait_states  input  4  wait states inserted per transfer; sampled in setup phase.
pready  output  1  transfer completion.
prdata  output  DATA_WIDTH  read data.
pslverr  output  1  transfer error (slave_error_e encoding).
err_count  output  8  saturating count of errored transfers.

Behaviour:
- Reset (preset_n low, asynchronous):
  - State goes to IDLE.
  - pready=0, prdata=0, pslverr=0, err_count=0.
  - Memory contents are NOT reset; the bench must write before it reads.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when a setup phase is seen (psel=1, penable=0).
  - In that transition cycle, latch paddr, pwrite, pwdata, pstrb and pprot, and load wait_cnt = cfg_wait_states.
  - ACCESS: when wait_cnt != 0, pready stays 0 and wait_cnt decrements each cycle.
  - ACCESS: when wait_cnt == 0, pready=1 for exactly one cycle, then return to IDLE.
  - A back-to-back setup phase in the cycle after completion is legal; IDLE accepts it immediately.
- Latency: all outputs are registered. With cfg_wait_states=N, pready rises in access cycle N+1 (N=0 means no wait). The transfer therefore spans N+2 cycles including setup.
- Error conditions, evaluated on the latched fields:
  - (a) address outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8 - 1];
  - (b) paddr low bits not aligned to DATA_WIDTH/8;
  - (c) a write with pstrb == 0;
  - (d) pprot[0] == 0 on an address in the upper half of memory (privileged-only region).
- pslverr is asserted only in the pready=1 cycle and is 0 in every other cycle.
- An errored write does not modify memory. An errored read returns prdata=0.
- err_count increments on each errored completion and saturates at 8'hFF.
- Write commit: on the completion cycle, memory word (paddr-BASE_ADDR)>>log2(DATA_WIDTH/8) is updated only in the byte lanes where pstrb=1.
- Read: prdata is driven with the word in the completion cycle and holds that value until the next read completes. The value is stable when pready=1.
- Read ignores pstrb; a nonzero pstrb on a read is not an error.
- Protocol violation: if psel drops or penable is 0 while in ACCESS, abort.
  - Go to IDLE, no memory write, pready stays 0, err_count unchanged.
  - The abort takes precedence over completion in the same cycle.
- Mid-transfer changes: paddr/pwdata changes during ACCESS are ignored because the values are latched at setup.
- Reset mid-transfer: the transfer is dropped immediately and no partial write occurs.

Decomposition:
- Add typedef apb_slave_state_e {IDLE, ACCESS} to apb_global_pkg.
- Reuse the package types slave_error_e, tx_type_e and protection_type_e, plus DATA_WIDTH and ADDRESS_WIDTH.
- One sub-module, apb_slave_byte_mem: a MEM_WORDS x DATA_WIDTH array with a byte-strobed synchronous write port and a combinational read port. It has no reset.
- The FSM, wait counter, error check and output registers stay in apb_slave_mem_responder.

Test Plan:
1. Write 0xDEADBEEF to BASE+0x4 with pstrb=4'hF and 0 waits, then read 0x4 -> pready rises in the first access cycle; prdata=0xDEADBEEF; pslverr=0.
2. Write 0xAABBCCDD to 0x8, then write 0x11223344 to 0x8 with pstrb=4'b0101, then read -> prdata=0xAA22CC44.
3. Set cfg_wait_states=3 and read 0x4 -> pready=0 for 3 access cycles and 1 in the 4th; the transfer spans 5 cycles.
4. Write to address BASE+0x40 (out of range, MEM_WORDS=16), then misaligned address 0x2, then a write with pstrb=0 -> pslverr=1 on each completion; memory unchanged; err_count=3.
5. Write with pprot=3'b000 to 0x20, then with pprot=3'b001 -> the first errors; the second succeeds and reads back correctly.
6. With 5 waits, deassert psel at wait 2, then separately assert preset_n=0 mid-transfer -> in both cases no pready pulse and no memory change. Outputs are 0 after reset, and a fresh transfer completes normally.
